// File: rtl/lsu_ctrl_pkg.sv
// Shared types for the load/store sequencer: scalar aliases, access size and FSM state.
package lsu_ctrl_pkg;

  typedef logic        u1;
  typedef logic [31:0] u32;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } size_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WRITE,
    RESP
  } lsu_state_t;

  // The reserved encoding 2'b11 behaves as a full word.
  function automatic size_t decode_size(input logic [1:0] raw);
    case (raw)
      2'b00:   return BYTE;
      2'b01:   return HALF;
      default: return WORD;
    endcase
  endfunction

endpackage

// File: rtl/lsu_ctrl_lane.sv
// Combinational lane logic: little-endian load extract/extend and sub-word store merge.
module lsu_lane
  import lsu_ctrl_pkg::*;
(
  input  logic [1:0] i_addr_lo,
  input  size_t      i_size,
  input  u1          i_uns,
  input  u32         i_word,
  input  u32         i_wdata,
  output u32         o_load_data,
  output u32         o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    w_byte      = i_word[7:0];
    w_half      = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
    o_load_data = i_word;
    o_merged    = i_word;

    case (i_addr_lo)
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      2'd3:    w_byte = i_word[31:24];
      default: ;
    endcase

    case (i_size)
      BYTE: begin
        o_load_data = {{24{w_byte[7] & ~i_uns}}, w_byte};
        case (i_addr_lo)
          2'd0: o_merged[7:0]   = i_wdata[7:0];
          2'd1: o_merged[15:8]  = i_wdata[7:0];
          2'd2: o_merged[23:16] = i_wdata[7:0];
          2'd3: o_merged[31:24] = i_wdata[7:0];
        endcase
      end
      HALF: begin
        o_load_data = {{16{w_half[15] & ~i_uns}}, w_half};
        if (i_addr_lo[1]) o_merged[31:16] = i_wdata[15:0];
        else              o_merged[15:0]  = i_wdata[15:0];
      end
      default: o_merged = i_wdata;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer in front of a word-only dmem; sub-word stores use read-modify-write.
// Define LSU_MISALIGN_EXC_EN to flag misaligned half/word accesses instead of aligning them down.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_uns,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata
);

  lsu_state_t        r_state;
  lsu_state_t        w_next;
  logic [1:0]        r_lo;
  size_t             r_size;
  u1                 r_uns;
  u1                 r_write;
  u1                 r_resp_valid;
  u1                 r_resp_err;
  u32                r_resp_rdata;
  logic [ADDR_W-1:0] r_dmem_addr;
  u32                r_dmem_wdata;

  u1  w_misalign;
  u1  w_we;
  u1  w_rmw;
  u32 w_load;
  u32 w_merged;

  // r_dmem_wdata holds the right-aligned store data until ACCESS turns it into the merged word.
  lsu_lane u_lane (
    .i_addr_lo   (r_lo),
    .i_size      (r_size),
    .i_uns       (r_uns),
    .i_word      (dmem_rdata),
    .i_wdata     (r_dmem_wdata),
    .o_load_data (w_load),
    .o_merged    (w_merged)
  );

`ifdef LSU_MISALIGN_EXC_EN
  assign w_misalign = ((r_size == HALF) && r_lo[0]) ||
                      ((r_size == WORD) && (r_lo != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_rmw = r_write && !w_misalign && (r_size != WORD);

  always_comb begin
    w_next = r_state;
    w_we   = 1'b0;
    case (r_state)
      IDLE:   if (req_valid) w_next = ACCESS;
      ACCESS: begin
        if (w_rmw) begin
          w_next = WRITE;
        end else begin
          w_next = RESP;
          w_we   = r_write && !w_misalign;
        end
      end
      WRITE: begin
        w_we   = 1'b1;
        w_next = RESP;
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
    // The strobe must drop in the very cycle reset is raised, not one edge later.
    if (reset) begin
      w_next = IDLE;
      w_we   = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lo         <= 2'b00;
      r_size       <= BYTE;
      r_uns        <= 1'b0;
      r_write      <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
      r_dmem_addr  <= '0;
      r_dmem_wdata <= '0;
    end else begin
      r_resp_valid <= (w_next == RESP);
      r_resp_err   <= (r_state == ACCESS) && w_misalign;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_lo         <= req_addr[1:0];
            r_size       <= decode_size(req_size);
            r_uns        <= req_uns;
            r_write      <= req_write;
            r_dmem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
            r_dmem_wdata <= req_wdata;
          end
        end
        ACCESS: begin
          r_resp_rdata <= (r_write || w_misalign) ? '0 : w_load;
          if (w_rmw) r_dmem_wdata <= w_merged;
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = (r_state == IDLE) && !reset;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign dmem_we    = w_we;
  assign dmem_addr  = r_dmem_addr;
  assign dmem_wdata = r_dmem_wdata;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: directed requests push expected writes/responses, a monitor checks them.
module tb_lsu_ctrl;
  import lsu_ctrl_pkg::*;

  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_write = 1'b0;
  logic [1:0]        req_size = 2'b00;
  logic              req_uns = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [31:0]       req_wdata = '0;
  logic              req_ready;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [31:0]       dmem_wdata;
  logic [31:0]       dmem_rdata;

  logic [31:0] mem [0:63];
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  resp_t resp_q[$];
  wr_t   wr_q[$];

  lsu_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_uns    (req_uns),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata)
  );

  always #5 clk = ~clk;

  // Word memory: async read, write on the rising edge.
  assign dmem_rdata = mem[dmem_addr[7:2]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (dmem_we === 1'b1) mem[dmem_addr[7:2]] <= dmem_wdata;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every write strobe and every response must match the head of its queue.
  always @(negedge clk) begin
    wr_t   ew;
    resp_t er;
    if (dmem_we === 1'b1) begin
      if (wr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_we got addr=%h data=%h expected=none (cyc %0d)", dmem_addr, dmem_wdata, cyc);
      end else begin
        ew = wr_q.pop_front();
        check("we_cycle", cyc, ew.cyc);
        check("we_addr", dmem_addr, ew.addr);
        check("we_data", dmem_wdata, ew.data);
      end
    end
    if (resp_valid === 1'b1) begin
      if (resp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp got rdata=%h err=%b expected=none (cyc %0d)", resp_rdata, resp_err, cyc);
      end else begin
        er = resp_q.pop_front();
        check("resp_cycle", cyc, er.cyc);
        check("resp_rdata", resp_rdata, er.rdata);
        check("resp_err", {31'b0, resp_err}, {31'b0, er.err});
      end
    end
  end

  task automatic drain();
    int n = 0;
    while ((resp_q.size() != 0 || wr_q.size() != 0) && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (resp_q.size() != 0 || wr_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got pending_resp=%0d pending_wr=%0d expected=0", resp_q.size(), wr_q.size());
      resp_q.delete();
      wr_q.delete();
    end
  endtask

  // One request; exp_word is the word the store must write (ignored for loads/errors).
  task automatic issue(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] exp_rdata, input logic exp_err,
                       input logic [31:0] exp_word);
    int  n = 0;
    int  acc;
    bit  sub;
    @(negedge clk);
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (req_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout got req_ready=%b expected=1", req_ready);
      return;
    end
    req_valid = 1'b1;
    req_write = w;
    req_size  = sz;
    req_uns   = u;
    req_addr  = a;
    req_wdata = wd;
    acc = cyc + 1;
    sub = w && (sz == 2'b00 || sz == 2'b01) && !exp_err;
    if (w && !exp_err) wr_q.push_back('{acc + (sub ? 1 : 0), a & ~32'd3, exp_word});
    resp_q.push_back('{acc + (sub ? 2 : 1), exp_rdata, exp_err});
    @(negedge clk);
    req_valid = 1'b0;
    req_write = 1'b0;
    drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[4] = 32'h8899AABB;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", {31'b0, req_ready}, 32'd0);
    check("rst_dmem_we", {31'b0, dmem_we}, 32'd0);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_resp_err", {31'b0, resp_err}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_dmem_addr", dmem_addr, 32'd0);
    check("rst_dmem_wdata", dmem_wdata, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_req_ready", {31'b0, req_ready}, 32'd1);

    issue(0, 2'b00, 0, 32'h13, 32'h0, 32'hFFFFFF88, 0, 32'h0);  // LB
    issue(0, 2'b00, 1, 32'h13, 32'h0, 32'h00000088, 0, 32'h0);  // LBU
    issue(0, 2'b01, 0, 32'h12, 32'h0, 32'hFFFF8899, 0, 32'h0);  // LH
    issue(0, 2'b01, 1, 32'h10, 32'h0, 32'h0000AABB, 0, 32'h0);  // LHU
    issue(1, 2'b00, 0, 32'h11, 32'h000000CC, 32'h0, 0, 32'h8899CCBB);  // SB
    issue(0, 2'b10, 0, 32'h10, 32'h0, 32'h8899CCBB, 0, 32'h0);  // LW
    issue(0, 2'b00, 1, 32'h12, 32'h0, 32'h00000099, 0, 32'h0);  // LBU lane 2
    issue(0, 2'b00, 0, 32'h10, 32'h0, 32'hFFFFFFBB, 0, 32'h0);  // LB lane 0
    issue(1, 2'b10, 0, 32'h20, 32'hDEADBEEF, 32'h0, 0, 32'hDEADBEEF);  // SW
    issue(0, 2'b10, 0, 32'h20, 32'h0, 32'hDEADBEEF, 0, 32'h0);  // LW
`ifdef LSU_MISALIGN_EXC_EN
    issue(0, 2'b10, 0, 32'h22, 32'h0, 32'h0, 1, 32'h0);         // misaligned LW
`else
    issue(0, 2'b10, 0, 32'h22, 32'h0, 32'hDEADBEEF, 0, 32'h0);
`endif
    issue(1, 2'b01, 0, 32'h22, 32'h00001234, 32'h0, 0, 32'h1234BEEF);  // SH upper half
    issue(0, 2'b01, 0, 32'h22, 32'h0, 32'h00001234, 0, 32'h0);  // LH positive
`ifdef LSU_MISALIGN_EXC_EN
    issue(1, 2'b01, 0, 32'h23, 32'h0000ABCD, 32'h0, 1, 32'h0);  // misaligned SH, no write
    issue(0, 2'b10, 0, 32'h20, 32'h0, 32'h1234BEEF, 0, 32'h0);
    issue(0, 2'b01, 0, 32'h21, 32'h0, 32'h0, 1, 32'h0);         // misaligned LH
`else
    issue(1, 2'b01, 0, 32'h23, 32'h0000ABCD, 32'h0, 0, 32'hABCDBEEF);
    issue(0, 2'b10, 0, 32'h20, 32'h0, 32'hABCDBEEF, 0, 32'h0);
    issue(0, 2'b01, 0, 32'h21, 32'h0, 32'hFFFFBEEF, 0, 32'h0);
`endif
    issue(0, 2'b11, 0, 32'h10, 32'h0, 32'h8899CCBB, 0, 32'h0);  // size 11 as word

    // SH interrupted by reset during its WRITE cycle: nothing may be written or answered.
    @(negedge clk);
    check("sh_rst_ready", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_size  = 2'b01;
    req_addr  = 32'h10;
    req_wdata = 32'h00001111;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_write = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("write_rst_ready", {31'b0, req_ready}, 32'd0);
    check("write_rst_we", {31'b0, dmem_we}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("post_rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("post_rst_dmem_addr", dmem_addr, 32'd0);
    check("post_rst_dmem_wdata", dmem_wdata, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_rst", {31'b0, req_ready}, 32'd1);
    check("mem_0x10_unchanged", mem[4], 32'h8899CCBB);
    issue(0, 2'b10, 0, 32'h10, 32'h0, 32'h8899CCBB, 0, 32'h0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
